// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants for the ALU result display: segment patterns, FSM encodings
// and the BCD digit to active-low segment decoder.
package seg_display_ctrl_pkg;

  // Active-low patterns, bit6..0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Converter FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  // Scan positions
  localparam logic [1:0] IDX_ONES = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd1;
  localparam logic [1:0] IDX_HUND = 2'd2;
  localparam logic [1:0] IDX_STAT = 2'd3;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Load/status/display bundle between the ALU side, the controller and the pins.
interface seg_display_ctrl_if;
  logic        load;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic [11:0] digits;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (output load, data, input busy, done, digits, seg, an);
  modport slave  (input load, data, output busy, done, digits, seg, an);
endinterface

// File: rtl/seg_display_ctrl_bcd.sv
// Serial 8-bit binary to 3-digit BCD converter (double-dabble), one step per
// clock. fin is high for the single LATCH cycle while result holds the answer.
module seg_display_ctrl_bcd
  import seg_display_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        fin,
  output logic [11:0] result
);

  logic [1:0]  state;
  logic [2:0]  step;
  logic [19:0] sr;

  // One double-dabble step: bias nibbles >= 5 by 3, then shift left
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++)
      if (t[8 + 4*i +: 4] >= 4'd5) t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  // FSM, step counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      step  <= 3'd0;
      sr    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          sr    <= {12'h000, bin_in};
          step  <= 3'd0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          sr   <= dabble(sr);
          step <= step + 3'd1;
          if (step == 3'd7) state <= ST_LATCH;
        end
        ST_LATCH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign fin    = (state == ST_LATCH);
  assign result = sr[19:8];

endmodule

// File: rtl/seg_display_ctrl.sv
// ALU result display controller: accepts a load when idle, converts serially
// to BCD, latches the digits atomically and scans four common-anode digits.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  seg_display_ctrl_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic          conv_busy, conv_fin, accept;
  logic [11:0]   conv_res;
  logic [11:0]   digits;
  logic          done;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, nidx;
  logic          wrap;
  logic [6:0]    seg_nxt;

  // Loads arriving while a conversion is in flight are dropped, not queued
  assign accept = bus.load && !conv_busy;

  seg_display_ctrl_bcd u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .bin_in (bus.data),
    .busy   (conv_busy),
    .fin    (conv_fin),
    .result (conv_res)
  );

  // Displayed value only moves at LATCH so the old number shows during a conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= 12'h000;
      done   <= 1'b0;
    end else begin
      done <= conv_fin;
      if (conv_fin) digits <= conv_res;
    end
  end

  assign wrap = (cnt == CW'(REFRESH_DIV - 1));
  assign nidx = wrap ? idx + 2'd1 : idx;

  // Segment pattern for the digit being enabled on this edge
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (nidx)
      IDX_ONES: seg_nxt = seg_encode(digits[3:0]);
      IDX_TENS: seg_nxt = (LZ_BLANK && digits[11:4] == 8'h00) ? SEG_BLANK
                                                              : seg_encode(digits[7:4]);
      IDX_HUND: seg_nxt = (LZ_BLANK && digits[11:8] == 4'h0) ? SEG_BLANK
                                                             : seg_encode(digits[11:8]);
      IDX_STAT: seg_nxt = conv_busy ? SEG_DASH : SEG_BLANK;
      default:  seg_nxt = SEG_BLANK;
    endcase
  end

  // Refresh counter, scan index and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      bus.seg  <= SEG_BLANK;
      bus.an   <= 4'b1111;
    end else begin
      cnt      <= wrap ? '0 : cnt + 1'b1;
      idx      <= nidx;
      bus.seg  <= seg_nxt;
      bus.an   <= ~(4'b0001 << nidx);
    end
  end

  assign bus.busy   = conv_busy;
  assign bus.done   = done;
  assign bus.digits = digits;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: three instances (DIV=4, DIV=4 with leading-zero
// blanking, DIV=1) tracked by a cycle model; converted values go through a
// scoreboard queue pushed on acceptance and popped on done.
module tb_seg_display_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seg_display_ctrl_if if4();
  seg_display_ctrl_if iflz();
  seg_display_ctrl_if if1();

  seg_display_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) u_d4  (.clk(clk), .rst(rst), .bus(if4));
  seg_display_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) u_dlz (.clk(clk), .rst(rst), .bus(iflz));
  seg_display_ctrl #(.REFRESH_DIV(1), .LZ_BLANK(1'b0)) u_d1  (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic        p_rst;
    logic        p_load;
    logic [7:0]  p_data;
    int          cnt;
    int          rcnt;
    int          idx;
    logic [11:0] dig;
    logic [11:0] pend;
  } mdl_t;

  mdl_t        m[3];
  logic [11:0] q[3][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int x;
    x = v;
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] t[10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 4'd10) ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] dg, input logic bsy,
                                         input int idx, input bit lz);
    case (idx)
      0:       return enc(dg[3:0]);
      1:       return (lz && dg[11:4] == 8'h00) ? 7'b1111111 : enc(dg[7:4]);
      2:       return (lz && dg[11:8] == 4'h0) ? 7'b1111111 : enc(dg[11:8]);
      default: return bsy ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Advance instance model by one edge (inputs seen at the previous negedge) and compare
  task automatic mon(input int id, input int div, input bit lz,
                     input logic r, input logic ld, input logic [7:0] d,
                     input logic bsy, input logic dn, input logic [11:0] dig,
                     input logic [6:0] sg, input logic [3:0] an);
    mdl_t       s;
    logic [6:0] es;
    logic [3:0] ea;
    logic       ed;
    int         nidx;
    s  = m[id];
    ed = 1'b0;
    if (s.p_rst) begin
      es = 7'b1111111;
      ea = 4'b1111;
      s.cnt = 0; s.rcnt = 0; s.idx = 0; s.dig = 12'h000;
      q[id].delete();
      chk($sformatf("u%0d.rst_digits", id), dig, 12'h000);
    end else begin
      nidx = (s.rcnt == div - 1) ? (s.idx + 1) % 4 : s.idx;
      es   = exp_seg(s.dig, s.cnt != 0, nidx, lz);
      ea   = ~(4'b0001 << nidx);
      s.rcnt = (s.rcnt == div - 1) ? 0 : s.rcnt + 1;
      s.idx  = nidx;
      if (s.cnt == 0) begin
        if (s.p_load) begin
          s.cnt  = 9;
          s.pend = to_bcd(s.p_data);
          q[id].push_back(s.pend);
        end
      end else begin
        s.cnt--;
        if (s.cnt == 0) begin
          ed    = 1'b1;
          s.dig = s.pend;
        end
      end
    end
    chk($sformatf("u%0d.seg", id), sg, es);
    chk($sformatf("u%0d.an", id), an, ea);
    chk($sformatf("u%0d.busy", id), bsy, s.cnt != 0);
    chk($sformatf("u%0d.done", id), dn, ed);
    if (dn === 1'b1) begin
      if (q[id].size() == 0) chk($sformatf("u%0d.sb_empty", id), 1, 0);
      else chk($sformatf("u%0d.digits", id), dig, q[id].pop_front());
    end
    s.p_rst  = r;
    s.p_load = ld;
    s.p_data = d;
    m[id] = s;
  endtask

  always @(negedge clk) mon(0, 4, 1'b0, rst, if4.load, if4.data, if4.busy, if4.done,
                            if4.digits, if4.seg, if4.an);
  always @(negedge clk) mon(1, 4, 1'b1, rst, iflz.load, iflz.data, iflz.busy, iflz.done,
                            iflz.digits, iflz.seg, iflz.an);
  always @(negedge clk) mon(2, 1, 1'b0, rst, if1.load, if1.data, if1.busy, if1.done,
                            if1.digits, if1.seg, if1.an);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m[i].p_rst = 1'b1; m[i].p_load = 1'b0; m[i].p_data = 8'h00;
      m[i].cnt = 0; m[i].rcnt = 0; m[i].idx = 0;
      m[i].dig = 12'h000; m[i].pend = 12'h000;
    end
    if4.load = 1'b0;  if4.data = 8'h00;
    iflz.load = 1'b0; iflz.data = 8'h00;
    if1.load = 1'b0;  if1.data = 8'h00;

    // Reset for 3 cycles, then free-run the scan
    tick(3);
    rst = 1'b0;
    tick(20);

    // 255 on the plain instance
    if4.load = 1'b1; if4.data = 8'd255;
    tick(1);
    if4.load = 1'b0;
    tick(30);

    // Leading-zero blanking: 7 then 100
    iflz.load = 1'b1; iflz.data = 8'd7;
    tick(1);
    iflz.load = 1'b0;
    tick(25);
    iflz.load = 1'b1; iflz.data = 8'd100;
    tick(1);
    iflz.load = 1'b0;
    tick(25);

    // Load held through busy: 42 taken, 99 ignored until the done cycle
    if4.load = 1'b1; if4.data = 8'd42;
    tick(1);
    if4.data = 8'd99;
    tick(9);
    tick(1);
    if4.load = 1'b0;
    tick(20);

    // A few random values back to back at full rate
    for (int k = 0; k < 4; k++) begin
      if4.load = 1'b1; if4.data = 8'($urandom_range(0, 255));
      tick(1);
      if4.load = 1'b0;
      tick(9);
    end
    tick(10);

    // Reset at the 4th shift step of 200 aborts the conversion
    if4.load = 1'b1; if4.data = 8'd200;
    tick(1);
    if4.load = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(20);

    // Full sweep on the fast-scan instance
    for (int v = 0; v < 256; v++) begin
      if1.load = 1'b1; if1.data = 8'(v);
      tick(1);
      if1.load = 1'b0;
      tick(9);
    end
    tick(10);

    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d.sb_left", i), q[i].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
